// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider. Each channel has an active divisor,
// a shadow divisor that is applied only on a period boundary, and a phase counter.
module multi_clock_divider #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 20,
    parameter int DEFAULT_DIV = 10000,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              inClock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enable,
    input  logic              syncAll,
    input  logic              wrEn,
    input  logic [CH_W-1:0]   wrChannel,
    input  logic [DIV_W-1:0]  wrDivisor,
    output logic              wrAck,
    output logic              wrErr,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] outClock,
    output logic [NUM_CH-1:0] tick
);

    logic [DIV_W-1:0]  div_q    [NUM_CH];
    logic [DIV_W-1:0]  shadow_q [NUM_CH];
    logic [DIV_W-1:0]  cnt_q    [NUM_CH];
    logic [NUM_CH-1:0] en_q;

    logic [DIV_W-1:0]  div_d    [NUM_CH];
    logic [DIV_W-1:0]  shadow_d [NUM_CH];
    logic [DIV_W-1:0]  cnt_d    [NUM_CH];
    logic [NUM_CH-1:0] pend_d;
    logic [NUM_CH-1:0] out_d;
    logic [NUM_CH-1:0] tick_d;

    logic              wr_valid;
    logic              restart;
    logic              apply;
    logic [DIV_W-1:0]  cnt_nx;
    logic [DIV_W-1:0]  div_eff;

    assign wr_valid = ({1'b0, wrChannel} < (CH_W+1)'(NUM_CH));

    always_comb begin
        div_d    = div_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        pend_d   = pending;
        out_d    = '0;
        tick_d   = '0;
        restart  = 1'b0;
        apply    = 1'b0;
        cnt_nx   = '0;
        div_eff  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            // A stopped channel (D==0) restarts from phase 0 as soon as a new D lands.
            restart = enable[i] && (!en_q[i] || syncAll || div_q[i] == '0);
            if (!enable[i] || restart || cnt_q[i] == div_q[i] - 1'b1)
                cnt_nx = '0;
            else
                cnt_nx = cnt_q[i] + 1'b1;

            apply   = pending[i] && (!enable[i] || div_q[i] == '0 || cnt_nx == '0);
            div_eff = apply ? shadow_q[i] : div_q[i];

            div_d[i]  = div_eff;
            pend_d[i] = apply ? 1'b0 : pending[i];
            cnt_d[i]  = (div_eff == '0) ? '0 : cnt_nx;

            if (enable[i] && div_eff != '0) begin
                out_d[i]  = (cnt_nx < (div_eff >> 1));
                tick_d[i] = (cnt_nx == '0);
            end

            // A write on the applying edge wins: the new value stays pending.
            if (wrEn && wr_valid && wrChannel == CH_W'(i)) begin
                shadow_d[i] = wrDivisor;
                pend_d[i]   = 1'b1;
            end
        end
    end

    always_ff @(posedge inClock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                div_q[i]    <= DIV_W'(DEFAULT_DIV);
                shadow_q[i] <= DIV_W'(DEFAULT_DIV);
                cnt_q[i]    <= '0;
            end
            en_q     <= '0;
            pending  <= '0;
            outClock <= '0;
            tick     <= '0;
            wrAck    <= 1'b0;
            wrErr    <= 1'b0;
        end else begin
            div_q    <= div_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            en_q     <= enable;
            pending  <= pend_d;
            outClock <= out_d;
            tick     <= tick_d;
            wrAck    <= wrEn && wr_valid;
            wrErr    <= wrEn && !wr_valid;
        end
    end

endmodule
